ap_ctrl_driver: RTL and testbench
=================================

# ap_ctrl_driver

Synthesizable initiator for the ap_ctrl_hs block-level handshake of a non-dataflow HLS kernel (ap_start / ap_ready / ap_done / ap_idle).
- Issues a programmed number of back-to-back kernel invocations and holds exactly one in flight.
- Measures per-call latency and min/max/total statistics, and flags a hung kernel via a watchdog.
- Drives the kernel's control port that the simulation-side monitors only observe, and raises `finish` when the run completes.

## Interface
Parameters:
- CNT_W, 32, width of latency/statistics counters
- TXN_W, 16, width of transaction count

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- go  in  1  one-cycle pulse: start a run (sampled only in IDLE or DONE)
- cfg_num_txn  in  TXN_W  invocations per run, sampled on accepted go
- cfg_timeout  in  CNT_W  watchdog limit in cycles, 0 = disabled, sampled on accepted go
- ap_start  out  1  kernel start request
- ap_ready  in  1  kernel accepted inputs
- ap_done  in  1  kernel finished one call
- ap_idle  in  1  kernel idle (checked before each start)
- busy  out  1  run in progress
- finish  out  1  run ended (level)
- timeout_err  out  1  watchdog fired during this run
- txn_count  out  TXN_W  completed calls this run
- last_latency  out  CNT_W  latency of most recent call
- min_latency  out  CNT_W  minimum latency this run
- max_latency  out  CNT_W  maximum latency this run
- total_cycles  out  CNT_W  cycles from accepted go to finish

## Operation
States: IDLE, ARM, START, WAIT_DONE, DONE, ERR.
- IDLE/DONE/ERR + go:
  - cfg_num_txn=0: -> DONE, finish=1, counters cleared.
  - Otherwise: -> ARM, clear txn_count/last/max/total, min=all-ones, finish=0, timeout_err=0.
- ARM: wait for ap_idle=1, then -> START. ap_start stays 0.
- START: ap_start=1 and held until ap_ready=1 is sampled. lat_cnt=1 in the first START cycle, +1 each later cycle.
  - ap_ready=1 and ap_done=1 in the same cycle: complete the call in that cycle.
  - ap_ready=1 alone: -> WAIT_DONE, ap_start=0 from the next cycle.
- WAIT_DONE: ap_start=0; wait for ap_done=1.
- Call completion, on the ap_done cycle:
  - last_latency=lat_cnt; min/max updated against lat_cnt; txn_count+1.
  - txn_count+1 == cfg_num_txn: -> DONE. Otherwise -> ARM.
- Watchdog: cfg_timeout≠0 and lat_cnt==cfg_timeout with no ap_done in that cycle -> ERR.
  - ERR: ap_start=0, timeout_err=1, finish=1. Statistics are frozen.
  - ap_done in the same cycle as the limit wins: normal completion.
- busy=1 in ARM, START, WAIT_DONE.
- total_cycles increments every busy cycle and saturates at all-ones. lat_cnt and total_cycles saturate; they never wrap.
- go while busy is ignored.
- ap_ready or ap_done while ap_start has never been asserted in this call (ARM, IDLE) is ignored.

## Timing
- Reset values: ap_start=0, busy=0, finish=0, timeout_err=0, txn_count=0, last_latency=0, min_latency=all-ones, max_latency=0, total_cycles=0. State=IDLE.
- Reset mid-run: the next edge forces reset values and ap_start drops within that edge. No completion is recorded.
- go accepted at edge N: ap_start rises at edge N+2 at the earliest (ARM one cycle, ap_idle=1).
- Back-to-back calls: ap_done at edge M -> ARM at M+1 -> ap_start=1 at M+2 (if ap_idle=1). Minimum gap is one low cycle.
- finish and statistics are valid in the same cycle busy falls. finish holds until the next accepted go or reset.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Kernel model: ap_ready in the first start cycle, ap_done 83 cycles later, ap_idle=1. cfg_num_txn=3, cfg_timeout=0, go -> three ap_start pulses of 1 cycle each. txn_count=3, last=min=max=84, finish=1, timeout_err=0.
- Varying delays: ap_ready delayed 5 cycles, done latencies 10, 4, 20 -> ap_start held 6 cycles on the first call, min=4, max=20, last=20.
- ap_ready and ap_done both in the first START cycle, cfg_num_txn=2 -> each latency=1, ap_start low exactly one cycle between calls.
- cfg_timeout=50, kernel never asserts ap_done -> ERR after the 50th start-relative cycle, ap_start=0, timeout_err=1, finish=1, txn_count=0. Repeat with ap_done at exactly cycle 50 -> normal completion, latency=50.
- cfg_num_txn=0 plus go -> finish=1 next cycle, ap_start never asserted, min=all-ones. ap_idle=0 held 7 cycles after go -> ap_start delayed 7 cycles.
- Reset asserted in WAIT_DONE of the second of 4 calls -> all outputs at reset values next cycle. A go while busy is ignored. A fresh go runs cleanly.

Source files
------------

// File: rtl/ap_ctrl_driver.sv
`default_nettype none
// ============================================================================
// Module      : ap_ctrl_driver
// Description : ap_ctrl_hs initiator for a non-dataflow HLS kernel. Issues a
//               programmed number of calls one at a time, measures per-call
//               latency statistics and guards each call with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ctrl_driver #(
    parameter int CNT_W = 32,
    parameter int TXN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [TXN_W-1:0] cfg_num_txn,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             busy,
    output logic             finish,
    output logic             timeout_err,
    output logic [TXN_W-1:0] txn_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] total_cycles
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARM       = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    localparam logic [CNT_W-1:0] C_CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TXN_W-1:0] C_TXN_ONE  = {{(TXN_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q,  state_d;
    logic [TXN_W-1:0] num_q,    num_d;
    logic [CNT_W-1:0] tmo_q,    tmo_d;
    logic [CNT_W-1:0] lat_q,    lat_d;
    logic [TXN_W-1:0] txn_q,    txn_d;
    logic [CNT_W-1:0] last_q,   last_d;
    logic [CNT_W-1:0] min_q,    min_d;
    logic [CNT_W-1:0] max_q,    max_d;
    logic [CNT_W-1:0] total_q,  total_d;
    logic             finish_q, finish_d;
    logic             terr_q,   terr_d;
    logic             start_q;
    logic             busy_q;

    logic             w_busy_now;
    logic             w_busy_next;
    logic             w_call_done;
    logic [TXN_W-1:0] w_txn_inc;

    assign w_busy_now  = (state_q == S_ARM) || (state_q == S_START) || (state_q == S_WAIT_DONE);
    assign w_busy_next = (state_d == S_ARM) || (state_d == S_START) || (state_d == S_WAIT_DONE);
    // In START a call only completes once the kernel has also accepted its inputs.
    assign w_call_done = (state_q == S_START) ? (ap_ready && ap_done) : ap_done;
    assign w_txn_inc   = txn_q + C_TXN_ONE;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        tmo_d    = tmo_q;
        lat_d    = lat_q;
        txn_d    = txn_q;
        last_d   = last_q;
        min_d    = min_q;
        max_d    = max_q;
        total_d  = total_q;
        finish_d = finish_q;
        terr_d   = terr_q;

        if (w_busy_now && (total_q != C_CNT_ONES)) begin
            total_d = total_q + C_CNT_ONE;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    num_d   = cfg_num_txn;
                    tmo_d   = cfg_timeout;
                    txn_d   = '0;
                    last_d  = '0;
                    max_d   = '0;
                    min_d   = C_CNT_ONES;
                    total_d = '0;
                    terr_d  = 1'b0;
                    if (cfg_num_txn == '0) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d  = S_ARM;
                        finish_d = 1'b0;
                    end
                end
            end
            S_ARM: begin
                if (ap_idle) begin
                    state_d = S_START;
                    lat_d   = C_CNT_ONE;
                end
            end
            S_START, S_WAIT_DONE: begin
                if (lat_q != C_CNT_ONES) begin
                    lat_d = lat_q + C_CNT_ONE;
                end
                // Completion beats the watchdog when both land in the same cycle.
                if (w_call_done) begin
                    last_d = lat_q;
                    txn_d  = w_txn_inc;
                    if (lat_q < min_q) min_d = lat_q;
                    if (lat_q > max_q) max_d = lat_q;
                    if (w_txn_inc == num_q) begin
                        state_d  = S_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d  = S_ARM;
                    end
                end else if ((tmo_q != '0) && (lat_q == tmo_q)) begin
                    state_d  = S_ERR;
                    terr_d   = 1'b1;
                    finish_d = 1'b1;
                end else if ((state_q == S_START) && ap_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            tmo_q    <= '0;
            lat_q    <= '0;
            txn_q    <= '0;
            last_q   <= '0;
            min_q    <= C_CNT_ONES;
            max_q    <= '0;
            total_q  <= '0;
            finish_q <= 1'b0;
            terr_q   <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            tmo_q    <= tmo_d;
            lat_q    <= lat_d;
            txn_q    <= txn_d;
            last_q   <= last_d;
            min_q    <= min_d;
            max_q    <= max_d;
            total_q  <= total_d;
            finish_q <= finish_d;
            terr_q   <= terr_d;
            start_q  <= (state_d == S_START);
            busy_q   <= w_busy_next;
        end
    end

    assign ap_start     = start_q;
    assign busy         = busy_q;
    assign finish       = finish_q;
    assign timeout_err  = terr_q;
    assign txn_count    = txn_q;
    assign last_latency = last_q;
    assign min_latency  = min_q;
    assign max_latency  = max_q;
    assign total_cycles = total_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ap_ctrl_driver
// Description : Directed self-checking bench; the bench plays the kernel and
//               keeps a latency scoreboard plus a min/max/total model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_driver;

    localparam int CNT_W = 32;
    localparam int TXN_W = 16;
    localparam logic [CNT_W-1:0] C_ONES = {CNT_W{1'b1}};

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             go = 1'b0;
    logic [TXN_W-1:0] cfg_num_txn = '0;
    logic [CNT_W-1:0] cfg_timeout = '0;
    logic             ap_start;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_idle = 1'b1;
    logic             busy;
    logic             finish;
    logic             timeout_err;
    logic [TXN_W-1:0] txn_count;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] min_latency;
    logic [CNT_W-1:0] max_latency;
    logic [CNT_W-1:0] total_cycles;

    ap_ctrl_driver #(.CNT_W(CNT_W), .TXN_W(TXN_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .cfg_num_txn  (cfg_num_txn),
        .cfg_timeout  (cfg_timeout),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .busy         (busy),
        .finish       (finish),
        .timeout_err  (timeout_err),
        .txn_count    (txn_count),
        .last_latency (last_latency),
        .min_latency  (min_latency),
        .max_latency  (max_latency),
        .total_cycles (total_cycles)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    logic [CNT_W-1:0] m_min;
    logic [CNT_W-1:0] m_max;
    logic [CNT_W-1:0] m_last;
    logic [TXN_W-1:0] m_txn;
    logic [CNT_W-1:0] m_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ap_start"}, ap_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_txn_count"}, txn_count, 0);
        chk({tag, "_last"}, last_latency, 0);
        chk({tag, "_min"}, min_latency, C_ONES);
        chk({tag, "_max"}, max_latency, 0);
        chk({tag, "_total"}, total_cycles, 0);
    endtask

    // Called at a negedge; returns at the negedge where the DUT is in ARM (or DONE).
    task automatic start_run(input int n, input int tmo);
        go          = 1'b1;
        cfg_num_txn = TXN_W'(n);
        cfg_timeout = CNT_W'(tmo);
        @(negedge clock);
        go      = 1'b0;
        m_min   = C_ONES;
        m_max   = '0;
        m_last  = '0;
        m_txn   = '0;
        m_total = '0;
    endtask

    // Kernel model for one call: ap_ready in START cycle rd+1, ap_done when latency hits lat.
    task automatic do_call(input int rd, input int lat, input int exp_gap);
        int low;
        int hi;
        int exp;
        exp_q.push_back(lat);
        low = 0;
        while ((ap_start !== 1'b1) && (low < 200)) begin
            low++;
            @(negedge clock);
        end
        if (ap_start !== 1'b1) begin
            chk("start_wait_expired", 0, 1);
            void'(exp_q.pop_back());
            return;
        end
        chk("arm_gap", low, exp_gap);
        hi = 0;
        for (int k = 1; k <= lat; k++) begin
            if (ap_start === 1'b1) hi++;
            ap_ready = (k == rd + 1);
            ap_done  = (k == lat);
            @(negedge clock);
        end
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        chk("start_high_cycles", hi, rd + 1);
        exp = exp_q.pop_front();
        m_txn++;
        m_last = CNT_W'(exp);
        if (m_last < m_min) m_min = m_last;
        if (m_last > m_max) m_max = m_last;
        m_total = m_total + CNT_W'(exp_gap + lat);
        chk("last_latency", last_latency, m_last);
        chk("txn_count", txn_count, m_txn);
    endtask

    task automatic chk_run_end(input string tag);
        chk({tag, "_finish"}, finish, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_txn"}, txn_count, m_txn);
        chk({tag, "_min"}, min_latency, m_min);
        chk({tag, "_max"}, max_latency, m_max);
        chk({tag, "_last"}, last_latency, m_last);
        chk({tag, "_total"}, total_cycles, m_total);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        // Fixed-latency kernel: ready on first START cycle, done 83 cycles later.
        start_run(3, 0);
        for (int i = 0; i < 3; i++) do_call(0, 84, 1);
        chk_run_end("fixed84");

        // Delayed ready and varying latencies.
        start_run(3, 0);
        do_call(5, 10, 1);
        do_call(0, 4, 1);
        do_call(0, 20, 1);
        chk_run_end("varying");

        // Ready and done together in the first START cycle.
        start_run(2, 0);
        do_call(0, 1, 1);
        do_call(0, 1, 1);
        chk_run_end("same_cycle");

        // Hung kernel trips the watchdog after 50 cycles.
        start_run(1, 50);
        for (int i = 0; (i < 200) && (ap_start !== 1'b1); i++) @(negedge clock);
        for (int k = 1; k <= 50; k++) begin
            ap_ready = (k == 1);
            if (k == 50) chk("wd_busy_at_limit", busy, 1);
            @(negedge clock);
        end
        ap_ready = 1'b0;
        chk("wd_ap_start", ap_start, 0);
        chk("wd_timeout_err", timeout_err, 1);
        chk("wd_finish", finish, 1);
        chk("wd_txn", txn_count, 0);
        chk("wd_busy", busy, 0);

        // Done exactly at the limit completes normally.
        start_run(1, 50);
        do_call(0, 50, 1);
        chk_run_end("wd_edge");

        // Zero-call run ends immediately.
        start_run(0, 0);
        m_total = '0;
        chk("zero_finish", finish, 1);
        chk("zero_busy", busy, 0);
        chk("zero_min", min_latency, C_ONES);
        chk("zero_txn", txn_count, 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (ap_start === 1'b1) seen++;
                @(negedge clock);
            end
            chk("zero_no_start", seen, 0);
        end

        // Kernel not idle for 7 cycles after go delays ap_start by 7 cycles.
        ap_idle = 1'b0;
        start_run(1, 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 7; i++) begin
                if (ap_start === 1'b1) seen++;
                @(negedge clock);
            end
            chk("idle_hold_no_start", seen, 0);
        end
        ap_idle = 1'b1;
        do_call(0, 3, 1);
        m_total = m_total + CNT_W'(7);
        chk_run_end("idle_delay");

        // Reset in WAIT_DONE of the second of four calls.
        start_run(4, 0);
        do_call(0, 5, 1);
        for (int i = 0; (i < 200) && (ap_start !== 1'b1); i++) @(negedge clock);
        ap_ready = 1'b1;
        @(negedge clock);
        ap_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_reset_values("midrun_reset");

        // A go during ARM is ignored; the original two-call run completes.
        start_run(2, 0);
        go          = 1'b1;
        cfg_num_txn = TXN_W'(1);
        @(negedge clock);
        go = 1'b0;
        do_call(0, 6, 0);
        m_total = m_total + CNT_W'(1);
        chk("ignored_go_busy", busy, 1);
        do_call(0, 9, 1);
        chk_run_end("ignored_go");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
